// File: rtl/guvm_icr_pkg.sv
// Shared types and constants for the instruction-cache responder.
package guvm_icr_pkg;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STARVE,
    ST_RESP
  } icr_state_e;

  // Instruction word width carried by a FIFO entry.
  localparam int unsigned ICR_DW = 32;

  // SPARC NOP returned when a starved fetch times out.
  localparam logic [ICR_DW-1:0] NOP_INSTR = 32'h0100_0000;

  // Consecutive STARVE cycles before a NOP is substituted.
  localparam int unsigned STARVE_LIMIT = 8;

  // One queued instruction together with its exception flag.
  typedef struct packed {
    logic              exc;
    logic [ICR_DW-1:0] data;
  } icr_entry_t;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO with synchronous clear. DEPTH must be a power of two so
// the pointers wrap by natural overflow. A push while full is taken only when
// a pop happens in the same cycle, so occupancy stays at DEPTH.
module guvm_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 33,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use <= so every flop samples pre-edge values
    // regardless of statement order; = here would create order-dependent races.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; entries are only read once count says
    // they were written, and leaving it unreset lets it map onto plain RAM.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/guvm_icache_responder.sv
// Instruction-cache responder: answers core fetches from a preloaded FIFO
// after LAT stall cycles, using hold=0 as the stall indication.
// Optional feature macro: GUVM_ICR_NOP_FILL_EN (NOP substitution after a
// prolonged starve instead of waiting indefinitely).
module guvm_icache_responder
  import guvm_icr_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  input  logic [DW-1:0]              ld_data,
  input  logic                       ld_exc,
  output logic                       ld_ready,
  input  logic                       flush,
  input  logic                       req,
  input  logic [31:0]                req_addr,
  output logic [DW-1:0]              data,
  output logic                       exception,
  output logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                last_addr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  icr_state_e state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   last_addr_q;
  logic [DW-1:0] data_q;
  logic          exc_q;

  icr_entry_t    wr_entry;
  icr_entry_t    head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  logic          push_ok;
  logic          pop;
  logic          resp_nop;
  logic          avail_next;
  logic          fetch_start;
  logic [DW-1:0] resp_data;
  logic          resp_exc;

`ifdef GUVM_ICR_NOP_FILL_EN
  logic [3:0] starve_q, starve_d;
  logic       nop_q, nop_d;
  assign resp_nop = nop_q;
`else
  assign resp_nop = 1'b0;
`endif

  // A NOP response consumes nothing from the FIFO.
  assign pop         = (state_q == ST_RESP) && !resp_nop && !fifo_empty;
  // Full FIFO still takes a word when the head leaves in the same cycle.
  assign push_ok     = ld_valid && !flush && (!fifo_full || pop);
  // FIFO will hold a word next cycle: what survives this pop plus any push.
  assign avail_next  = (fifo_count > CW'(pop)) || push_ok;
  // A new fetch may start from IDLE or back-to-back from RESP.
  assign fetch_start = req && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  assign wr_entry.exc  = ld_exc;
  assign wr_entry.data = ld_data;

  guvm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(icr_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clr   (flush),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, wait counter and response mux.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    hold      = 1'b1;
    resp_data = data_q;
    resp_exc  = exc_q;
`ifdef GUVM_ICR_NOP_FILL_EN
    starve_d  = '0;
    nop_d     = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        hold   = 1'b0;
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) state_d = avail_next ? ST_RESP : ST_STARVE;
      end
      ST_STARVE: begin
        hold = 1'b0;
        if (avail_next) begin
          state_d = ST_RESP;
`ifdef GUVM_ICR_NOP_FILL_EN
        end else if (starve_q == 4'(STARVE_LIMIT - 1)) begin
          state_d = ST_RESP;
          nop_d   = 1'b1;
        end else begin
          starve_d = starve_q + 4'd1;
`endif
        end
      end
      ST_RESP: begin
        resp_data = resp_nop ? NOP_INSTR : head.data;
        resp_exc  = resp_nop ? 1'b0 : head.exc;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fetch_start) begin
      addr_d = req_addr;
      wait_d = 4'(LAT);
      if (LAT > 0) state_d = ST_WAIT;
      else         state_d = avail_next ? ST_RESP : ST_STARVE;
    end

    // Flush aborts any fetch in flight and overrides a concurrent request.
    if (flush) begin
      state_d = ST_IDLE;
      wait_d  = '0;
`ifdef GUVM_ICR_NOP_FILL_EN
      starve_d = '0;
      nop_d    = 1'b0;
`endif
    end
  end

  // FSM state, captured address and the held response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      data_q      <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      if (state_q == ST_RESP) begin
        data_q      <= resp_data;
        exc_q       <= resp_exc;
        last_addr_q <= addr_q;
      end
    end
  end

`ifdef GUVM_ICR_NOP_FILL_EN
  // Starve timeout counter and NOP-response marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      nop_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      nop_q    <= nop_d;
    end
  end
`endif

  assign data      = resp_data;
  assign exception = resp_exc;
  assign ld_ready  = !fifo_full;
  assign count     = fifo_count;
  assign last_addr = last_addr_q;

endmodule

// File: tb/tb_guvm_icache_responder.sv
// Directed bench: instance a uses LAT=2, instance b uses LAT=0; both share
// the same input stimulus and each test flushes first to start from empty.
module tb_guvm_icache_responder;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0100_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_exc;
  logic          flush;
  logic          req;
  logic [31:0]   req_addr;

  logic          a_ready, a_exc, a_hold;
  logic [31:0]   a_data, a_last;
  logic [CW-1:0] a_count;
  logic          b_ready, b_exc, b_hold;
  logic [31:0]   b_data, b_last;
  logic [CW-1:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  guvm_icache_responder #(.DEPTH(DEPTH), .LAT(2), .DW(32)) u_a (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_exc(ld_exc),
    .ld_ready(a_ready), .flush(flush), .req(req), .req_addr(req_addr),
    .data(a_data), .exception(a_exc), .hold(a_hold), .count(a_count), .last_addr(a_last)
  );

  guvm_icache_responder #(.DEPTH(DEPTH), .LAT(0), .DW(32)) u_b (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_exc(ld_exc),
    .ld_ready(b_ready), .flush(flush), .req(req), .req_addr(req_addr),
    .data(b_data), .exception(b_exc), .hold(b_hold), .count(b_count), .last_addr(b_last)
  );

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic e);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_exc   = e;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_exc   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %0b want 1", a_hold); end
    checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data); end
    checks++; if (a_exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %0b want 0", a_exc); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", a_ready); end
    checks++; if (a_count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
    checks++; if (a_last !== 32'h0) begin errors++; $display("FAIL reset_last: got %h want 0", a_last); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_flush();
    push_word(32'h8E00_C002, 1'b0);
    push_word(32'h8210_2001, 1'b0);
    req = 1'b1; req_addr = 32'h4000_0000;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (a_hold !== 1'b0) begin errors++; $display("FAIL lat_wait%0d_hold: got %0b want 0", i, a_hold); end
      @(negedge clk);
    end
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL lat_resp_hold: got %0b want 1", a_hold); end
    checks++; if (a_data !== 32'h8E00_C002) begin errors++; $display("FAIL lat_resp_data: got %h want 8e00c002", a_data); end
    checks++; if (a_count !== CW'(2)) begin errors++; $display("FAIL lat_resp_count: got %0d want 2", a_count); end
    @(negedge clk);
    checks++; if (a_last !== 32'h4000_0000) begin errors++; $display("FAIL lat_last: got %h want 40000000", a_last); end
    checks++; if (a_count !== CW'(1)) begin errors++; $display("FAIL lat_count_after: got %0d want 1", a_count); end
    checks++; if (a_data !== 32'h8E00_C002) begin errors++; $display("FAIL lat_idle_data: got %h want 8e00c002", a_data); end
  endtask

  task automatic test_lat0_stream();
    logic [31:0] words [3];
    words[0] = 32'hA000_0001; words[1] = 32'hA000_0002; words[2] = 32'hA000_0003;
    do_flush();
    for (int i = 0; i < 3; i++) push_word(words[i], 1'b0);
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'h1000 + 32'(4 * i);
      @(negedge clk);
      checks++; if (b_hold !== 1'b1) begin errors++; $display("FAIL lat0_hold%0d: got %0b want 1", i, b_hold); end
      checks++; if (b_data !== words[i]) begin errors++; $display("FAIL lat0_data%0d: got %h want %h", i, b_data, words[i]); end
      checks++; if (b_count !== CW'(3 - i)) begin errors++; $display("FAIL lat0_count%0d: got %0d want %0d", i, b_count, 3 - i); end
    end
    req = 1'b0;
    @(negedge clk);
    checks++; if (b_count !== CW'(0)) begin errors++; $display("FAIL lat0_drained: got %0d want 0", b_count); end
    checks++; if (b_last !== 32'h1008) begin errors++; $display("FAIL lat0_last: got %h want 00001008", b_last); end
  endtask

  task automatic test_starve();
    do_flush();
    req = 1'b1; req_addr = 32'h2000;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_hold !== 1'b0) begin errors++; $display("FAIL starve_hold%0d: got %0b want 0", i, a_hold); end
      if (i < 3) @(negedge clk);
    end
    push_word(NOP, 1'b0);
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL starve_resp_hold: got %0b want 1", a_hold); end
    checks++; if (a_data !== NOP) begin errors++; $display("FAIL starve_resp_data: got %h want %h", a_data, NOP); end
    @(negedge clk);
    checks++; if (a_count !== CW'(0)) begin errors++; $display("FAIL starve_count: got %0d want 0", a_count); end
    checks++; if (a_last !== 32'h2000) begin errors++; $display("FAIL starve_last: got %h want 00002000", a_last); end
  endtask

  task automatic test_starve_long();
    do_flush();
    req = 1'b1; req_addr = 32'h3000;
    @(negedge clk);
    req = 1'b0;
    // Two WAIT cycles followed by eight STARVE cycles.
    for (int i = 0; i < 10; i++) begin
      checks++; if (a_hold !== 1'b0) begin errors++; $display("FAIL long_hold%0d: got %0b want 0", i, a_hold); end
      @(negedge clk);
    end
`ifdef GUVM_ICR_NOP_FILL_EN
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL nop_hold: got %0b want 1", a_hold); end
    checks++; if (a_data !== NOP) begin errors++; $display("FAIL nop_data: got %h want %h", a_data, NOP); end
    checks++; if (a_exc !== 1'b0) begin errors++; $display("FAIL nop_exc: got %0b want 0", a_exc); end
    @(negedge clk);
    checks++; if (a_last !== 32'h3000) begin errors++; $display("FAIL nop_last: got %h want 00003000", a_last); end
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL nop_idle_hold: got %0b want 1", a_hold); end
`else
    for (int i = 0; i < 10; i++) begin
      checks++; if (a_hold !== 1'b0) begin errors++; $display("FAIL starve_forever%0d: got %0b want 0", i, a_hold); end
      @(negedge clk);
    end
    do_flush();
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL starve_flush_hold: got %0b want 1", a_hold); end
    checks++; if (a_last !== 32'h2000) begin errors++; $display("FAIL starve_flush_last: got %h want 00002000", a_last); end
`endif
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i), 1'b0);
    checks++; if (a_count !== CW'(16)) begin errors++; $display("FAIL full_count: got %0d want 16", a_count); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", a_ready); end
    push_word(32'hDEAD, 1'b0);
    checks++; if (a_count !== CW'(16)) begin errors++; $display("FAIL full_drop_count: got %0d want 16", a_count); end
    req = 1'b1; req_addr = 32'h4000;
    @(negedge clk);
    req = 1'b0;
    checks++; if (b_data !== 32'h100) begin errors++; $display("FAIL full_head: got %h want 00000100", b_data); end
    // Push lands in the same cycle the head pops.
    push_word(32'hBEEF, 1'b0);
    checks++; if (b_count !== CW'(16)) begin errors++; $display("FAIL full_pushpop_count: got %0d want 16", b_count); end
    req = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      checks++; if (b_data !== 32'h100 + 32'(i)) begin errors++; $display("FAIL full_order%0d: got %h want %h", i, b_data, 32'h100 + 32'(i)); end
    end
    @(negedge clk);
    req = 1'b0;
    checks++; if (b_data !== 32'hBEEF) begin errors++; $display("FAIL full_tail: got %h want 0000beef", b_data); end
    @(negedge clk);
    checks++; if (b_count !== CW'(0)) begin errors++; $display("FAIL full_drained: got %0d want 0", b_count); end
  endtask

  task automatic test_exception();
    do_flush();
    push_word(32'h1234_5678, 1'b1);
    push_word(32'h9ABC_DEF0, 1'b0);
    req = 1'b1; req_addr = 32'h5000;
    @(negedge clk);
    checks++; if (b_exc !== 1'b1) begin errors++; $display("FAIL exc_set: got %0b want 1", b_exc); end
    checks++; if (b_data !== 32'h1234_5678) begin errors++; $display("FAIL exc_data: got %h want 12345678", b_data); end
    @(negedge clk);
    req = 1'b0;
    checks++; if (b_exc !== 1'b0) begin errors++; $display("FAIL exc_clear: got %0b want 0", b_exc); end
    checks++; if (b_data !== 32'h9ABC_DEF0) begin errors++; $display("FAIL exc_next_data: got %h want 9abcdef0", b_data); end
  endtask

  task automatic test_flush_reset();
    do_flush();
    for (int i = 0; i < 4; i++) push_word(32'h600 + 32'(i), 1'b0);
    req = 1'b1; req_addr = 32'h6000;
    @(negedge clk);
    req = 1'b0;
    checks++; if (a_hold !== 1'b0) begin errors++; $display("FAIL flush_pre_hold: got %0b want 0", a_hold); end
    do_flush();
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL flush_hold: got %0b want 1", a_hold); end
    checks++; if (a_count !== CW'(0)) begin errors++; $display("FAIL flush_count: got %0d want 0", a_count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL flush_no_resp%0d: got %0b want 1", i, a_hold); end
    end
    push_word(32'h700, 1'b0);
    push_word(32'h701, 1'b0);
    req = 1'b1; req_addr = 32'h7000;
    @(negedge clk);
    req = 1'b0;
    checks++; if (a_hold !== 1'b0) begin errors++; $display("FAIL rst_pre_hold: got %0b want 0", a_hold); end
    #2 rst = 1'b0;
    #1;
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %0b want 1", a_hold); end
    checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", a_data); end
    checks++; if (a_exc !== 1'b0) begin errors++; $display("FAIL rst_exc: got %0b want 0", a_exc); end
    checks++; if (a_count !== CW'(0)) begin errors++; $display("FAIL rst_count: got %0d want 0", a_count); end
    checks++; if (a_last !== 32'h0) begin errors++; $display("FAIL rst_last: got %h want 0", a_last); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", a_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_exc   = 1'b0;
    flush    = 1'b0;
    req      = 1'b0;
    req_addr = '0;
    test_reset();
    test_latency();
    test_lat0_stream();
    test_starve();
    test_starve_long();
    test_full();
    test_exception();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
